// File: rtl/mult_pack_scheduler.sv
// Request scheduler for a shared 9x9 multiplier that can split into two 4x4 lanes.
// Full requests issue alone; half requests are held and paired with a later
// same-signedness half request, or issued alone on conflict or timeout.
// Results (with requester tags) are queued in a small FIFO.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   in_valid/in_ready             request handshake
//   in_mode, in_sign              0 = full 9x9, 1 = half 4x4; signed operands
//   in_a, in_b, in_tag            operands and requester tag
//   mul_A, mul_B, mul_*_sign,
//   mul_HALF_0, mul_HALF_1        combinational multiplier controls (0 when idle)
//   mul_C                         combinational multiplier product
//   out_valid/out_ready           result FIFO handshake
//   out_result, out_tag           FIFO head
module mult_pack_scheduler #(
    parameter int unsigned HOLD_TIMEOUT = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic        in_sign,
    input  logic [8:0]  in_a,
    input  logic [8:0]  in_b,
    input  logic [3:0]  in_tag,
    output logic [8:0]  mul_A,
    output logic [8:0]  mul_B,
    output logic        mul_A_sign,
    output logic        mul_B_sign,
    output logic        mul_HALF_0,
    output logic        mul_HALF_1,
    input  logic [17:0] mul_C,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_result,
    output logic [3:0]  out_tag
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    typedef enum logic [0:0] {IDLE, HOLD} state_t;

    typedef struct packed {
        logic [17:0] result;
        logic [3:0]  tag;
    } entry_t;

    state_t         state, state_nxt;
    logic [3:0]     h_a, h_b, h_tag;
    logic           h_sign;
    logic [TW-1:0]  cnt;

    entry_t         mem [0:FIFO_DEPTH-1];
    logic [AW-1:0]  wptr, rptr;
    logic [CW-1:0]  count, free;

    logic           do_full, do_pair, do_alone, do_capture;
    logic           timed_out, pair_match, pop;
    logic [1:0]     push_n;
    entry_t         wr0, wr1;

    // Lane product to 18 bits, sign- or zero-extended
    function automatic logic [17:0] ext8(input logic [7:0] p, input logic s);
        return s ? {{10{p[7]}}, p} : {10'b0, p};
    endfunction

    assign free      = CW'(FIFO_DEPTH) - count;
    // cnt holds HOLD cycles already waited; the current cycle completes the timeout
    assign timed_out = (32'(cnt) + 32'd1) >= HOLD_TIMEOUT;
    assign pair_match = in_mode && (in_sign == h_sign);
    assign pop       = (count != '0) && out_ready;

    // Next-state, handshake, multiplier drive and FIFO write data
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        do_full    = 1'b0;
        do_pair    = 1'b0;
        do_alone   = 1'b0;
        do_capture = 1'b0;
        mul_A      = '0;
        mul_B      = '0;
        mul_A_sign = 1'b0;
        mul_B_sign = 1'b0;
        mul_HALF_0 = 1'b0;
        mul_HALF_1 = 1'b0;
        push_n     = 2'd0;
        wr0        = '0;
        wr1        = '0;

        if (!reset) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!in_mode) begin
                            if (free >= CW'(1)) begin
                                in_ready = 1'b1;
                                do_full  = 1'b1;
                            end
                        end else begin
                            in_ready   = 1'b1;
                            do_capture = 1'b1;
                            state_nxt  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (in_valid && pair_match) begin
                        if (free >= CW'(2)) begin
                            in_ready  = 1'b1;
                            do_pair   = 1'b1;
                            state_nxt = IDLE;
                        end else if (timed_out && free >= CW'(1)) begin
                            do_alone  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else if ((in_valid || timed_out) && free >= CW'(1)) begin
                        // Conflicting request or timeout: flush the held op alone
                        do_alone  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (do_full) begin
            mul_A      = in_a;
            mul_B      = in_b;
            mul_A_sign = in_sign;
            mul_B_sign = in_sign;
            mul_HALF_0 = 1'b1;
            push_n     = 2'd1;
            wr0        = '{result: mul_C, tag: in_tag};
        end
        if (do_pair) begin
            mul_A      = {in_a[3:0], 1'b0, h_a};
            mul_B      = {in_b[3:0], 1'b0, h_b};
            mul_A_sign = h_sign;
            mul_B_sign = h_sign;
            mul_HALF_1 = 1'b1;
            push_n     = 2'd2;
            wr0        = '{result: ext8(mul_C[7:0], h_sign), tag: h_tag};
            wr1        = '{result: ext8(mul_C[17:10], h_sign), tag: in_tag};
        end
        if (do_alone) begin
            mul_A      = {5'b0, h_a};
            mul_B      = {5'b0, h_b};
            mul_A_sign = h_sign;
            mul_B_sign = h_sign;
            mul_HALF_1 = 1'b1;
            push_n     = 2'd1;
            wr0        = '{result: ext8(mul_C[7:0], h_sign), tag: h_tag};
        end
    end

    // FSM state, held operand and hold counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            h_a    <= '0;
            h_b    <= '0;
            h_tag  <= '0;
            h_sign <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (do_capture) begin
                h_a    <= in_a[3:0];
                h_b    <= in_b[3:0];
                h_tag  <= in_tag;
                h_sign <= in_sign;
                cnt    <= '0;
            end else if (state == HOLD && state_nxt == HOLD && !timed_out) begin
                cnt <= cnt + TW'(1);
            end
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push_n);
            rptr  <= rptr + AW'(pop);
            count <= count + CW'(push_n) - CW'(pop);
        end
    end

    // FIFO storage (no reset needed; occupancy gates visibility)
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem[wptr] <= wr0;
        if (push_n == 2'd2) mem[wptr + AW'(1)] <= wr1;
    end

    assign out_valid  = (count != '0);
    assign out_result = mem[rptr].result;
    assign out_tag    = mem[rptr].tag;

endmodule

// File: tb/tb_mult_pack_scheduler.sv
module tb_mult_pack_scheduler;

    localparam int unsigned HOLD_TIMEOUT = 8;
    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int          NV           = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_mode, in_sign;
    logic [8:0]  in_a, in_b;
    logic [3:0]  in_tag;
    logic [8:0]  mul_A, mul_B;
    logic        mul_A_sign, mul_B_sign, mul_HALF_0, mul_HALF_1;
    logic [17:0] mul_C;
    logic        out_valid, out_ready;
    logic [17:0] out_result;
    logic [3:0]  out_tag;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [17:0] res;
        logic [3:0]  tag;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        mode;
        logic        sign;
        logic [8:0]  a;
        logic [8:0]  b;
        logic [3:0]  tag;
        logic [17:0] exp_res;
    } vec_t;
    vec_t vt [NV];

    mult_pack_scheduler #(.HOLD_TIMEOUT(HOLD_TIMEOUT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_sign(in_sign),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mul_A(mul_A), .mul_B(mul_B), .mul_A_sign(mul_A_sign), .mul_B_sign(mul_B_sign),
        .mul_HALF_0(mul_HALF_0), .mul_HALF_1(mul_HALF_1), .mul_C(mul_C),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Behavioural splittable multiplier driven by the scheduler
    always_comb begin
        int pa, pb, lo, hi;
        pa = 0; pb = 0; lo = 0; hi = 0;
        mul_C = '0;
        if (mul_HALF_1) begin
            lo = (mul_A_sign ? int'($signed(mul_A[3:0])) : int'(mul_A[3:0])) *
                 (mul_B_sign ? int'($signed(mul_B[3:0])) : int'(mul_B[3:0]));
            hi = (mul_A_sign ? int'($signed(mul_A[8:5])) : int'(mul_A[8:5])) *
                 (mul_B_sign ? int'($signed(mul_B[8:5])) : int'(mul_B[8:5]));
            mul_C = {8'(hi), 2'b00, 8'(lo)};
        end else begin
            pa = mul_A_sign ? int'($signed(mul_A)) : int'(mul_A);
            pb = mul_B_sign ? int'($signed(mul_B)) : int'(mul_B);
            mul_C = 18'(pa * pb);
        end
    end

    // Expected result of one request from plain arithmetic
    function automatic logic [17:0] ref_result(input logic mode, input logic sign,
                                                input logic [8:0] a, input logic [8:0] b);
        int x, y;
        logic [3:0] a4, b4;
        a4 = a[3:0];
        b4 = b[3:0];
        if (mode) begin
            x = sign ? int'($signed(a4)) : int'(a4);
            y = sign ? int'($signed(b4)) : int'(b4);
        end else begin
            x = sign ? int'($signed(a)) : int'(a);
            y = sign ? int'($signed(b)) : int'(b);
        end
        return 18'(x * y);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: results must come out in acceptance order; reset discards everything
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_result", 32'(out_result), 32'(e.res));
                    chk("sb_tag", 32'(out_tag), 32'(e.tag));
                end
            end
            if (in_valid && in_ready) begin
                e.res = ref_result(in_mode, in_sign, in_a, in_b);
                e.tag = in_tag;
                exp_q.push_back(e);
            end
        end
    end

    task automatic drive(input logic mode, input logic sign, input logic [8:0] a,
                         input logic [8:0] b, input logic [3:0] tag);
        in_valid = 1'b1; in_mode = mode; in_sign = sign; in_a = a; in_b = b; in_tag = tag;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  lat, issue_at, outs;
        logic seen, hs;

        vt[0] = '{1'b0, 1'b0, 9'd255,  9'd3,   4'd1,  18'd765};
        vt[1] = '{1'b0, 1'b1, 9'h100,  9'h1FF, 4'd2,  18'h00100};
        vt[2] = '{1'b0, 1'b0, 9'h1FF,  9'h1FF, 4'd3,  18'h3FC01};
        vt[3] = '{1'b0, 1'b1, 9'h0FF,  9'h101, 4'd4,  18'h301FF};
        vt[4] = '{1'b0, 1'b1, 9'h100,  9'h100, 4'd5,  18'h10000};
        vt[5] = '{1'b1, 1'b1, 9'h1F8,  9'h007, 4'd6,  18'h3FFC8};
        vt[6] = '{1'b1, 1'b0, 9'h00F,  9'h0AF, 4'd7,  18'd225};
        vt[7] = '{1'b1, 1'b1, 9'h008,  9'h008, 4'd8,  18'h00040};
        vt[8] = '{1'b1, 1'b1, 9'h007,  9'h00F, 4'd9,  18'h3FFF9};
        vt[9] = '{1'b1, 1'b0, 9'h000,  9'h009, 4'd10, 18'd0};

        reset = 1'b1; out_ready = 1'b0;
        in_valid = 1'b0; in_mode = 1'b0; in_sign = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 9'd5, 9'd5, 4'd0);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_mul", 32'({mul_A, mul_B, mul_A_sign, mul_B_sign, mul_HALF_0, mul_HALF_1}), 0);
        next_cycle();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 0);
        next_cycle();

        // Full unsigned issue timing
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 9'd255, 9'd3, 4'd1);
        @(negedge clk);
        chk("full_ready", 32'(in_ready), 1);
        chk("full_half0", 32'(mul_HALF_0), 1);
        chk("full_half1", 32'(mul_HALF_1), 0);
        chk("full_mulA", 32'(mul_A), 255);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_out_valid", 32'(out_valid), 1);
        chk("full_out_result", 32'(out_result), 765);
        chk("full_out_tag", 32'(out_tag), 1);
        next_cycle();

        // Table: single requests; halves issue alone after the timeout
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].mode, vt[i].sign, vt[i].a, vt[i].b, vt[i].tag);
            @(negedge clk);
            chk("tbl_ready", 32'(in_ready), 1);
            next_cycle();
            in_valid = 1'b0;
            lat = 0; seen = 1'b0;
            repeat (HOLD_TIMEOUT + 10) begin
                if (!seen) begin
                    @(negedge clk);
                    lat++;
                    if (out_valid) begin
                        seen = 1'b1;
                        chk("tbl_result", 32'(out_result), 32'(vt[i].exp_res));
                        chk("tbl_tag", 32'(out_tag), 32'(vt[i].tag));
                        chk("tbl_latency", 32'(lat), vt[i].mode ? HOLD_TIMEOUT + 1 : 1);
                    end
                    next_cycle();
                end
            end
            chk("tbl_seen", 32'(seen), 1);
        end

        // Pairing: two unsigned halves share one issue
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 9'd15, 9'd15, 4'd2);
        @(negedge clk);
        chk("pair_cap_ready", 32'(in_ready), 1);
        chk("pair_cap_noissue", 32'({mul_HALF_0, mul_HALF_1, mul_A}), 0);
        next_cycle();
        drive(1'b1, 1'b0, 9'd3, 9'd4, 4'd3);
        @(negedge clk);
        chk("pair_ready", 32'(in_ready), 1);
        chk("pair_mulA", 32'(mul_A), 32'h06F);
        chk("pair_mulB", 32'(mul_B), 32'h08F);
        chk("pair_halves", 32'({mul_HALF_0, mul_HALF_1}), 1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pair_out0", 32'({out_valid, out_result, out_tag}), 32'({1'b1, 18'd225, 4'd2}));
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("pair_out1", 32'({out_valid, out_result, out_tag}), 32'({1'b1, 18'd12, 4'd3}));
        next_cycle();
        @(negedge clk);
        chk("pair_drained", 32'(out_valid), 0);
        next_cycle();

        // Timeout: lone signed half issues exactly HOLD_TIMEOUT cycles after capture
        drive(1'b1, 1'b1, 9'h008, 9'h007, 4'd6);
        @(negedge clk);
        chk("to_cap_ready", 32'(in_ready), 1);
        next_cycle();
        in_valid = 1'b0;
        issue_at = -1;
        for (int k = 1; k <= int'(HOLD_TIMEOUT) + 4; k++) begin
            @(negedge clk);
            if (issue_at > 0 && k == issue_at + 1)
                chk("to_result", 32'(out_result), 32'h3FFC8);
            if (mul_HALF_1 && issue_at < 0) begin
                issue_at = k;
                chk("to_mulA", 32'(mul_A), 32'h008);
            end
            next_cycle();
        end
        chk("to_cycle", 32'(issue_at), HOLD_TIMEOUT);

        // Sign mismatch: held unsigned op flushed alone, signed op captured next cycle
        drive(1'b1, 1'b0, 9'd5, 9'd6, 4'd4);
        next_cycle();
        drive(1'b1, 1'b1, 9'h00F, 9'd2, 4'd5);
        @(negedge clk);
        chk("mm_ready_low", 32'(in_ready), 0);
        chk("mm_alone", 32'({mul_HALF_1, mul_A, mul_B}), 32'({1'b1, 9'h005, 9'h006}));
        next_cycle();
        @(negedge clk);
        chk("mm_capture", 32'(in_ready), 1);
        chk("mm_out", 32'({out_valid, out_result, out_tag}), 32'({1'b1, 18'd30, 4'd4}));
        next_cycle();
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (HOLD_TIMEOUT + 6) begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                chk("mm_second", 32'({out_result, out_tag}), 32'({18'h3FFFE, 4'd5}));
            end
            next_cycle();
        end
        chk("mm_second_seen", 32'(seen), 1);

        // Backpressure: four fulls fill the FIFO, fifth waits for a pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 9'(10 + i), 9'd3, 4'(8 + i));
            @(negedge clk);
            chk("bp_fill_ready", 32'(in_ready), 1);
            next_cycle();
        end
        drive(1'b0, 1'b0, 9'd20, 9'd3, 4'd12);
        repeat (3) begin
            @(negedge clk);
            chk("bp_full_ready", 32'(in_ready), 0);
            chk("bp_head", 32'({out_valid, out_result, out_tag}), 32'({1'b1, 18'd30, 4'd8}));
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_pop_credit", 32'(in_ready), 0);
        next_cycle();
        @(negedge clk);
        chk("bp_after_pop", 32'(in_ready), 1);
        next_cycle();
        in_valid = 1'b0;
        repeat (8) next_cycle();
        chk("bp_drained", 32'(exp_q.size()), 0);

        // Reset while holding: held op is discarded
        drive(1'b1, 1'b0, 9'd9, 9'd9, 4'd13);
        next_cycle();
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rh_ready", 32'(in_ready), 0);
        chk("rh_out_valid", 32'(out_valid), 0);
        next_cycle();
        reset = 1'b0;
        outs = 0;
        repeat (HOLD_TIMEOUT + 4) begin
            @(negedge clk);
            outs += int'(out_valid) + int'(mul_HALF_1);
            next_cycle();
        end
        chk("rh_no_output", 32'(outs), 0);
        drive(1'b0, 1'b0, 9'd7, 9'd9, 4'd15);
        @(negedge clk);
        chk("rh_full_ready", 32'(in_ready), 1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rh_full_out", 32'({out_valid, out_result, out_tag}), 32'({1'b1, 18'd63, 4'd15}));
        next_cycle();

        // Random traffic against the scoreboard
        hs = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || hs) begin
                in_valid = (c < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                in_mode  = 1'($urandom_range(0, 1));
                in_sign  = 1'($urandom_range(0, 1));
                in_a     = 9'($urandom);
                in_b     = 9'($urandom);
                in_tag   = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs = in_valid && in_ready;
            chk("rnd_half_excl", 32'(mul_HALF_0 & mul_HALF_1), 0);
            if (mul_HALF_1) chk("rnd_lane_gap", 32'({mul_A[4], mul_B[4]}), 0);
            next_cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (HOLD_TIMEOUT + 20) next_cycle();
        chk("rnd_drained", 32'(exp_q.size()), 0);
        chk("rnd_out_idle", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
